// File: rtl/asy_pulse_sync_hs.sv
// Multi-channel fast-to-slow pulse synchroniser. Each channel queues events in a
// saturating counter and sends them one at a time over a toggle req/ack handshake.
module asy_pulse_sync_hs #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic          clk_fast,
  input  logic          clk_slow,
  input  logic          rst_n,
  input  logic [CH-1:0] din,
  input  logic [CH-1:0] ovf_clr,
  output logic [CH-1:0] dout,
  output logic [CH-1:0] busy,
  output logic [CH-1:0] ovf
);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // The only two signals that cross domains; both are plain flop outputs.
  logic [CH-1:0] req_tgl;
  logic [CH-1:0] ack_tgl;

  for (genvar g = 0; g < CH; g++) begin : g_ch

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ovf_q;
    logic             ovf_nxt;
    logic             req_q;
    logic             req_nxt;
    logic             launch;
    logic             busy_ch;
    logic             ack_sync;
    logic             s_last;
    logic             s_d;

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] ack_pipe;
    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] req_pipe;

    // ---------------- fast domain: handshake FSM ----------------
    // NOTE: clocked state is always written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk_fast or negedge rst_n) begin
      if (!rst_n) begin
        state <= IDLE;
      end else begin
        state <= state_nxt;
      end
    end

    // NOTE: every signal gets a default first, so no path through the block infers a latch.
    always_comb begin
      state_nxt = state;
      case (state)
        IDLE:     if (cnt != '0)           state_nxt = WAIT_ACK;
        WAIT_ACK: if (ack_sync == req_q)   state_nxt = IDLE;
        default:                           state_nxt = IDLE;
      endcase
    end

    always_comb begin
      launch  = (state == IDLE) && (cnt != '0);
      busy_ch = (cnt != '0) || (state != IDLE);
    end

    // ---------------- fast domain: pending counter, overflow, request ----------------
    always_comb begin
      cnt_nxt = cnt;
      ovf_nxt = ovf_q;
      req_nxt = req_q;
      if (launch) begin
        req_nxt = ~req_q;
      end
      case ({din[g], launch})
        2'b10:   if (cnt != CNT_MAX) cnt_nxt = cnt + CNT_ONE;
        2'b01:   cnt_nxt = cnt - CNT_ONE;
        default: cnt_nxt = cnt;
      endcase
      // A drop in the same cycle as a clear keeps the flag set.
      if (din[g] && !launch && (cnt == CNT_MAX)) begin
        ovf_nxt = 1'b1;
      end else if (ovf_clr[g]) begin
        ovf_nxt = 1'b0;
      end
    end

    always_ff @(posedge clk_fast or negedge rst_n) begin
      if (!rst_n) begin
        cnt   <= '0;
        ovf_q <= 1'b0;
        req_q <= 1'b0;
      end else begin
        cnt   <= cnt_nxt;
        ovf_q <= ovf_nxt;
        req_q <= req_nxt;
      end
    end

    // Acknowledge toggle back into the fast domain.
    always_ff @(posedge clk_fast or negedge rst_n) begin
      if (!rst_n) begin
        ack_pipe <= '0;
      end else begin
        ack_pipe <= {ack_pipe[SYNC_STAGES-2:0], ack_tgl[g]};
      end
    end

    assign ack_sync = ack_pipe[SYNC_STAGES-1];

    // ---------------- slow domain: request sync and edge detect ----------------
    always_ff @(posedge clk_slow or negedge rst_n) begin
      if (!rst_n) begin
        req_pipe <= '0;
        s_d      <= 1'b0;
      end else begin
        req_pipe <= {req_pipe[SYNC_STAGES-2:0], req_tgl[g]};
        s_d      <= req_pipe[SYNC_STAGES-1];
      end
    end

    assign s_last = req_pipe[SYNC_STAGES-1];

    // Each request toggle shows up as exactly one slow cycle of s_last != s_d.
    assign dout[g]    = s_last ^ s_d;
    assign ack_tgl[g] = s_d;
    assign req_tgl[g] = req_q;
    assign busy[g]    = busy_ch;
    assign ovf[g]     = ovf_q;

  end : g_ch

endmodule

// File: tb/tb_asy_pulse_sync_hs.sv
// Directed bench for asy_pulse_sync_hs: one 4-channel instance at ~1:6 slow:fast,
// plus single-channel instances at 1:1 (three sync stages) and 2:1 (slow faster).
`timescale 1ns/1ps
module tb_asy_pulse_sync_hs;

  localparam int CH = 4;

  logic clk_fast = 1'b0;
  logic clk_slow = 1'b0;
  logic clk_eq   = 1'b0;
  logic clk_hi   = 1'b0;
  logic rst_n;

  logic [CH-1:0] din, ovf_clr, dout, busy, ovf;
  logic [0:0]    din_e, clr_e, dout_e, busy_e, ovf_e;
  logic [0:0]    din_h, clr_h, dout_h, busy_h, ovf_h;

  always #5   clk_fast = ~clk_fast;
  always #30  clk_slow = ~clk_slow;
  always #2.5 clk_hi   = ~clk_hi;
  initial begin
    #3;
    forever #5 clk_eq = ~clk_eq;
  end

  asy_pulse_sync_hs #(.CH(CH), .SYNC_STAGES(2), .CNT_W(4)) u_dut (
    .clk_fast(clk_fast), .clk_slow(clk_slow), .rst_n(rst_n),
    .din(din), .ovf_clr(ovf_clr), .dout(dout), .busy(busy), .ovf(ovf)
  );

  asy_pulse_sync_hs #(.CH(1), .SYNC_STAGES(3), .CNT_W(4)) u_eq (
    .clk_fast(clk_fast), .clk_slow(clk_eq), .rst_n(rst_n),
    .din(din_e), .ovf_clr(clr_e), .dout(dout_e), .busy(busy_e), .ovf(ovf_e)
  );

  asy_pulse_sync_hs #(.CH(1), .SYNC_STAGES(2), .CNT_W(4)) u_hi (
    .clk_fast(clk_fast), .clk_slow(clk_hi), .rst_n(rst_n),
    .din(din_h), .ovf_clr(clr_h), .dout(dout_h), .busy(busy_h), .ovf(ovf_h)
  );

  // Pulse counters and "high on two consecutive slow cycles" detectors.
  int dcnt [CH];
  int wide = 0;
  bit [CH-1:0] dprev = '0;
  int ecnt = 0, ewide = 0, hcnt = 0, hwide = 0;
  bit eprev = 1'b0, hprev = 1'b0;

  always @(negedge clk_slow) begin
    for (int i = 0; i < CH; i++) begin
      if (dout[i] === 1'b1) dcnt[i] <= dcnt[i] + 1;
    end
    wide  <= wide + $countones(dout & dprev);
    dprev <= dout;
  end

  always @(negedge clk_eq) begin
    if (dout_e === 1'b1) ecnt <= ecnt + 1;
    if (dout_e === 1'b1 && eprev) ewide <= ewide + 1;
    eprev <= (dout_e === 1'b1);
  end

  always @(negedge clk_hi) begin
    if (dout_h === 1'b1) hcnt <= hcnt + 1;
    if (dout_h === 1'b1 && hprev) hwide <= hwide + 1;
    hprev <= (dout_h === 1'b1);
  end

  int total = 0;
  int bad   = 0;
  int base [CH];
  int ebase, hbase;
  int nev [CH];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    for (int i = 0; i < CH; i++) base[i] = dcnt[i];
    ebase = ecnt;
    hbase = hcnt;
  endtask

  // Bounded wait for every channel of every instance to go idle.
  task automatic quiet(input string tag);
    int n = 0;
    while ((busy !== '0 || busy_e !== '0 || busy_h !== '0) && n < 3000) begin
      @(negedge clk_fast);
      n++;
    end
    repeat (3) @(negedge clk_slow);
    check(tag, {busy, busy_e, busy_h}, 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1);
  end

  initial begin
    din = '0; ovf_clr = '0;
    din_e = '0; clr_e = '0; din_h = '0; clr_h = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_dout", {dout, dout_e, dout_h}, 64'd0);
    check("rst_busy", {busy, busy_e, busy_h}, 64'd0);
    check("rst_ovf",  {ovf, ovf_e, ovf_h}, 64'd0);
    #149 rst_n = 1'b1;

    // 1: single event on channel 0
    @(negedge clk_fast);
    snap();
    check("t1_busy_pre", busy[0], 64'd0);
    din[0] = 1'b1;
    @(negedge clk_fast);
    din[0] = 1'b0;
    check("t1_busy_next", busy[0], 64'd1);
    quiet("t1_idle");
    check("t1_count", dcnt[0] - base[0], 64'd1);
    check("t1_ovf", ovf, 64'd0);

    // 2: five back-to-back events on channel 1
    snap();
    din[1] = 1'b1;
    repeat (5) @(negedge clk_fast);
    din[1] = 1'b0;
    quiet("t2_idle");
    check("t2_count", dcnt[1] - base[1], 64'd5);
    check("t2_others", {32'(dcnt[0] - base[0]), 16'(dcnt[2] - base[2]), 16'(dcnt[3] - base[3])}, 64'd0);

    // 3: 20-cycle burst, launch right after a slow edge: 1 in flight + 15 queued, 4 dropped
    snap();
    @(posedge clk_slow);
    #1 din[2] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 16) check("t3_ovf_before_drop", ovf[2], 64'd0);
      if (i == 17) check("t3_ovf_at_drop", ovf[2], 64'd1);
      @(negedge clk_fast);
    end
    din[2] = 1'b0;
    quiet("t3_idle");
    check("t3_count", dcnt[2] - base[2], 64'd16);
    check("t3_ovf_sticky", ovf[2], 64'd1);
    @(negedge clk_fast);
    ovf_clr[2] = 1'b1;
    @(negedge clk_fast);
    ovf_clr[2] = 1'b0;
    check("t3_ovf_clr", ovf[2], 64'd0);

    // 3b: 17-cycle burst drops only on the 17th edge, with ovf_clr in that same cycle
    snap();
    @(posedge clk_slow);
    #1 din[2] = 1'b1;
    for (int i = 0; i < 17; i++) begin
      if (i == 16) ovf_clr[2] = 1'b1;
      @(negedge clk_fast);
    end
    din[2] = 1'b0;
    ovf_clr[2] = 1'b0;
    check("t3_set_wins", ovf[2], 64'd1);
    quiet("t3b_idle");
    check("t3b_count", dcnt[2] - base[2], 64'd16);

    // 4: sparse random traffic on all channels
    @(negedge clk_fast);
    ovf_clr = '1;
    @(negedge clk_fast);
    ovf_clr = '0;
    check("t4_ovf_cleared", ovf, 64'd0);
    snap();
    for (int i = 0; i < CH; i++) nev[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < CH; i++) begin
        din[i] = ($urandom_range(63) == 0);
        if (din[i]) nev[i]++;
      end
      @(negedge clk_fast);
    end
    din = '0;
    quiet("t4_idle");
    for (int i = 0; i < CH; i++) begin
      check($sformatf("t4_count_ch%0d", i), dcnt[i] - base[i], 64'(nev[i]));
    end
    check("t4_ovf", ovf, 64'd0);

    // 5: reset while the third of eight events is in flight
    snap();
    din[3] = 1'b1;
    repeat (8) @(negedge clk_fast);
    din[3] = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk_slow);
      #1;
      if (dcnt[3] - base[3] >= 2) break;
    end
    check("t5_two_before_rst", dcnt[3] - base[3], 64'd2);
    #99 rst_n = 1'b0;
    #1;
    check("t5_rst_outputs", {dout, busy, ovf, dout_e, busy_e, ovf_e, dout_h, busy_h, ovf_h}, 64'd0);
    repeat (3) @(posedge clk_slow);
    #2 rst_n = 1'b1;
    repeat (20) @(negedge clk_slow);
    check("t5_no_residual", dcnt[3] - base[3], 64'd2);
    check("t5_busy_after", busy, 64'd0);
    @(negedge clk_fast);
    din[3] = 1'b1;
    @(negedge clk_fast);
    din[3] = 1'b0;
    quiet("t5_idle");
    check("t5_new_event", dcnt[3] - base[3], 64'd3);

    // 6: 1:1 with three sync stages, and slow clock at twice the fast rate
    snap();
    din_e = 1'b1;
    din_h = 1'b1;
    repeat (10) @(negedge clk_fast);
    din_e = 1'b0;
    din_h = 1'b0;
    quiet("t6_idle");
    check("t6_eq_count", ecnt - ebase, 64'd10);
    check("t6_hi_count", hcnt - hbase, 64'd10);
    check("t6_ovf", {ovf_e, ovf_h}, 64'd0);
    check("t6_width_eq_hi", ewide + hwide, 64'd0);
    check("pulse_width_main", wide, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/asy_pulse_sync_hs.md
Name: asy_pulse_sync_hs

Overview:
Multi-channel pulse synchroniser from clk_fast to clk_slow, using a toggle request/acknowledge handshake per channel.
Each channel has a saturating pending-pulse counter in the fast domain, so back-to-back or bursty input pulses are queued and delivered one by one, not dropped.
Each delivered pulse is exactly one clk_slow cycle wide.
Sits at fast-to-slow boundaries for event/interrupt/strobe transfer where the input has no minimum pulse spacing.

Parameters:
CH, 4, number of independent channels (>=1)
SYNC_STAGES, 2, synchroniser flops per crossing, both directions (>=2)
CNT_W, 4, pending-counter width per channel; queue depth = 2^CNT_W-1

Ports:
clk_fast  input  1  source clock; din, busy, ovf, ovf_clr domain
clk_slow  input  1  destination clock; dout domain
rst_n  input  1  reset, asynchronous, active-low, shared by both domains
din  input  CH  per-channel event; each clk_fast cycle high = one event
ovf_clr  input  CH  clk_fast; clears the sticky ovf bit of the channel
dout  output  CH  clk_slow; one-cycle pulse per delivered event
busy  output  CH  clk_fast; channel has pending or in-flight events
ovf  output  CH  clk_fast; sticky, events lost to counter saturation

Behaviour:
- Reset
  - rst_n low asynchronously clears all state in both domains: counters, FSMs, toggles, sync chains, ovf.
  - dout=0, busy=0, ovf=0.
  - Deassertion is synchronised to each clock outside this block.
  - Reset mid-operation discards pending and in-flight events; no dout pulse is produced for them.
- Fast domain, per channel
  - Registered pending counter cnt (CNT_W bits), FSM state {IDLE, WAIT_ACK}, request toggle req_tgl.
  - launch = (state==IDLE) && (cnt!=0), evaluated on registered values.
  - On launch: req_tgl flips, state -> WAIT_ACK.
  - Next cnt = cnt + din - launch.
    - din and launch in the same cycle: cnt unchanged.
  - Saturation: cnt==2^CNT_W-1 with din=1 and launch=0 -> cnt holds and ovf sets.
  - ovf_clr clears ovf; set wins if both occur in the same cycle.
  - WAIT_ACK -> IDLE when ack_sync == req_tgl.
    - ack_sync is ack_tgl passed through SYNC_STAGES clk_fast flops.
  - busy = (cnt!=0) || (state!=IDLE), combinational from registers.
- Slow domain, per channel
  - req_tgl passes through SYNC_STAGES clk_slow flops to give s_last, plus one delay flop s_d.
  - dout = s_last ^ s_d: exactly one clk_slow cycle per toggle.
  - ack_tgl = s_d, returned to the fast domain.
- Timing
  - Latency from launch to dout high: SYNC_STAGES clk_slow edges.
  - Handshake round trip: SYNC_STAGES+1 clk_slow cycles plus SYNC_STAGES clk_fast cycles; at most one event in flight per channel.
- Channels are fully independent; no shared state except the resets.
- All sync-chain flops carry ASYNC_REG. Only req_tgl and ack_tgl cross domains, and both are single-bit, glitch-free registers.
- Ordering and conservation: every event not lost to saturation produces exactly one dout pulse, in order.

Test Plan:
1. clk_fast 100 MHz, clk_slow 17 MHz, CH=4, default params. One 1-cycle din[0] pulse -> exactly one dout[0] pulse of 1 clk_slow cycle; busy[0] high from the next clk_fast cycle until the ack returns, then 0; ovf=0.
2. din[1] high for 5 consecutive clk_fast cycles -> exactly 5 dout[1] pulses, separated by the handshake round trip; busy[1] falls after the 5th ack; other channels stay quiet.
3. Overflow, CNT_W=4: din[2] high for 20 consecutive cycles -> 16 dout[2] pulses (1 in flight + 15 queued); ovf[2]=1 from the cycle the first event is dropped. ovf_clr[2] pulse afterwards -> ovf[2]=0. ovf_clr asserted in the same cycle as a drop -> ovf stays 1.
4. Concurrent channels: random din on all 4 channels for 10k clk_fast cycles, average rate below handshake throughput -> per-channel dout count equals din count; ovf all 0.
5. Reset mid-operation: burst of 8 on din[3], then rst_n low for 3 clk_slow cycles during the 3rd transfer -> all outputs 0 immediately. After release, no residual dout pulses; a new single pulse delivers exactly one dout.
6. Clock-ratio sweep: clk_slow/clk_fast ratios of 1:1, 1:3, 1:10, and clk_slow faster (2:1), SYNC_STAGES=2 and 3 -> event conservation holds; every dout pulse is exactly 1 clk_slow wide.
